polyphase_sched: RTL and testbench
==================================

POLYPHASE_SCHED -- requirements
Module: polyphase_sched

Interface
REQ-001 SHALL have parameter L, default 160, meaning interpolation factor (number of polyphase branches).
REQ-002 SHALL have parameter L_LOG, default 8, meaning phase index width; the bench SHALL check that L <= 2^L_LOG and M < 2^L_LOG hold.
REQ-003 SHALL have parameter M, default 147, meaning decimation factor (phase advance per output).
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-006 SHALL have port run, input, 1, level enable for starting new outputs.
REQ-007 SHALL have port req_in, output, 1, request for one upstream input sample.
REQ-008 SHALL have port ack_in, input, 1, upstream acknowledge; transfer occurs on a cycle with req_in && ack_in.
REQ-009 SHALL have port shift_en, output, 1, one-cycle pulse telling the datapath to shift the accepted sample into its delay line.
REQ-010 SHALL have port start, output, 1, one-cycle pulse telling the datapath to compute one output.
REQ-011 SHALL have port phase, output, L_LOG, coefficient branch for the current computation, held stable from start until the output handshake.
REQ-012 SHALL have port done, input, 1, datapath pulse marking the computed output as valid.
REQ-013 SHALL have port req_out, output, 1, request to downstream; output data valid.
REQ-014 SHALL have port ack_out, input, 1, downstream acknowledge; transfer occurs on a cycle with req_out && ack_out.
REQ-015 SHALL have port out_cnt, output, 16, count of completed output transfers, wrapping modulo 2^16.

Function
REQ-016 SHALL hold the phase accumulator acc, L_LOG+1 bits wide, so that acc+M never overflows.
REQ-017 SHALL implement the states ADVANCE, FETCH, START, WAIT and OUT.
REQ-018 In ADVANCE with acc >= L, SHALL do acc <= acc-L and go to FETCH; req_in SHALL be registered high on the same edge.
REQ-019 In ADVANCE with acc < L and run=1, SHALL go to START.
REQ-020 In ADVANCE with acc < L and run=0, SHALL stay in ADVANCE, so fetches still due complete before the block idles.
REQ-021 In FETCH, req_in SHALL stay high until a cycle with ack_in=1. On the next edge: req_in<=0, shift_en<=1 for exactly one cycle, state<=ADVANCE.
REQ-022 In START, SHALL drive start=1 for exactly one cycle with phase=acc[L_LOG-1:0], then go to WAIT.
REQ-023 In WAIT, on done=1, SHALL go to OUT and register req_out<=1 on the same edge.
REQ-024 In OUT, on ack_out=1, the next edge SHALL do req_out<=0, acc<=acc+M, out_cnt<=out_cnt+1, state<=ADVANCE.
REQ-025 SHALL ignore ack_in outside FETCH, ack_out outside OUT, and done outside WAIT, with no state change.
REQ-026 SHALL never assert req_in and req_out in the same cycle, and never assert shift_en and start in the same cycle.
REQ-027 Minimum latency: output with no fetch, 4 cycles ADVANCE->OUT plus the datapath done delay; each fetch adds 2 cycles plus the ack wait.
REQ-028 Over any L consecutive outputs, SHALL accept exactly M input samples; phase of output k SHALL equal (k*M) mod L.
REQ-029 For M >= L, SHALL perform multiple FETCH/ADVANCE loops per output, with no additional logic.
REQ-030 A de-asserted run SHALL not abort START, WAIT, OUT or FETCH in progress.

Reset
REQ-031 On rst=1 at a clock edge, regardless of state, SHALL set state=ADVANCE, acc=L, req_in=0, req_out=0, shift_en=0, start=0, phase=0, out_cnt=0.
REQ-032 Because acc resets to L, the first action after reset SHALL be one input fetch, followed by the phase-0 output.
REQ-033 Reset mid-handshake SHALL drop req_in/req_out on the next edge; the bench SHALL verify that no shift_en or start pulse follows.

Verification
REQ-034 Scenario: reset, run=1, ack_in and ack_out tied high, done 1 cycle after start -> first three outputs with phase 0, 147, 134; shift_en pulses before outputs 1 and 3 only.
REQ-035 Scenario: 160 outputs under the REQ-034 setup -> exactly 147 shift_en pulses, acc back at 0 before output 161, out_cnt=160.
REQ-036 Scenario: hold ack_out low 10 cycles in OUT -> req_out stays 1, phase stable, acc unchanged, no start pulse.
REQ-037 Scenario: rst asserted while req_in=1 in FETCH -> next cycle req_in=0, acc=L, out_cnt=0, then normal restart with a phase-0 output.
REQ-038 Scenario: run=0 asserted during WAIT -> current output completes and a pending fetch completes, then no start until run=1.
REQ-039 Scenario: done and ack_in pulsed during ADVANCE -> no state, acc or output change.

Source files
------------

// File: rtl/polyphase_sched_if.sv
// polyphase_sched_if: handshake bundle around the polyphase scheduler
// master (scheduler side) drives: req_in, shift_en, start, phase, req_out, out_cnt
// slave (environment side) drives: run, ack_in, done, ack_out
interface polyphase_sched_if #(
    parameter int L_LOG = 8
);
    logic run;
    logic req_in;
    logic ack_in;
    logic shift_en;
    logic start;
    logic [L_LOG-1:0] phase;
    logic done;
    logic req_out;
    logic ack_out;
    logic [15:0] out_cnt;
    modport master(
        input run, ack_in, done, ack_out,
        output req_in, shift_en, start, phase, req_out, out_cnt
    );
    modport slave(
        output run, ack_in, done, ack_out,
        input req_in, shift_en, start, phase, req_out, out_cnt
    );
endinterface

// File: rtl/polyphase_sched.sv
// polyphase_sched: L/M rational-rate polyphase scheduler (input fetch, branch select, output handshake)
// clk, rst      : rising-edge clock, synchronous active-high reset
// bus (master)  : run in; req_in/ack_in upstream sample handshake; shift_en, start, phase to datapath;
//                 done from datapath; req_out/ack_out downstream handshake; out_cnt completed outputs
module polyphase_sched #(
    parameter int L = 160,
    parameter int L_LOG = 8,
    parameter int M = 147
) (
    input logic clk,
    input logic rst,
    polyphase_sched_if.master bus
);
    typedef enum logic [2:0] {ADVANCE, FETCH, START, WAIT, OUT} state_t;
    localparam logic [L_LOG:0] L_A = (L_LOG+1)'(L);
    localparam logic [L_LOG:0] M_A = (L_LOG+1)'(M);
    state_t state_q, state_d;
    // One extra bit so acc+M cannot overflow; acc >= L means an input sample is still owed.
    logic [L_LOG:0] acc_q, acc_d;
    logic req_in_q, req_in_d;
    logic shift_en_q, shift_en_d;
    logic start_q, start_d;
    logic [L_LOG-1:0] phase_q, phase_d;
    logic req_out_q, req_out_d;
    logic [15:0] out_cnt_q, out_cnt_d;
    always_comb begin
        state_d = state_q;
        acc_d = acc_q;
        req_in_d = req_in_q;
        shift_en_d = 1'b0;
        start_d = 1'b0;
        phase_d = phase_q;
        req_out_d = req_out_q;
        out_cnt_d = out_cnt_q;
        unique case (state_q)
            ADVANCE: begin
                // Owed fetches take priority and ignore run, so the block only idles when caught up.
                if (acc_q >= L_A) begin
                    acc_d = acc_q - L_A;
                    req_in_d = 1'b1;
                    state_d = FETCH;
                end else if (bus.run) begin
                    start_d = 1'b1;
                    phase_d = acc_q[L_LOG-1:0];
                    state_d = START;
                end
            end
            FETCH: begin
                if (bus.ack_in) begin
                    req_in_d = 1'b0;
                    shift_en_d = 1'b1;
                    state_d = ADVANCE;
                end
            end
            START: state_d = WAIT;
            WAIT: begin
                if (bus.done) begin
                    req_out_d = 1'b1;
                    state_d = OUT;
                end
            end
            OUT: begin
                if (bus.ack_out) begin
                    req_out_d = 1'b0;
                    acc_d = acc_q + M_A;
                    out_cnt_d = out_cnt_q + 16'd1;
                    state_d = ADVANCE;
                end
            end
            default: state_d = ADVANCE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ADVANCE;
            acc_q <= L_A;
            req_in_q <= 1'b0;
            shift_en_q <= 1'b0;
            start_q <= 1'b0;
            phase_q <= '0;
            req_out_q <= 1'b0;
            out_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q <= acc_d;
            req_in_q <= req_in_d;
            shift_en_q <= shift_en_d;
            start_q <= start_d;
            phase_q <= phase_d;
            req_out_q <= req_out_d;
            out_cnt_q <= out_cnt_d;
        end
    end
    assign bus.req_in = req_in_q;
    assign bus.shift_en = shift_en_q;
    assign bus.start = start_q;
    assign bus.phase = phase_q;
    assign bus.req_out = req_out_q;
    assign bus.out_cnt = out_cnt_q;
endmodule

// File: tb/tb_polyphase_sched.sv
// tb_polyphase_sched: randomized bench checking polyphase_sched against a rate-conversion reference model
module tb_polyphase_sched;
    localparam int L = 160;
    localparam int L_LOG = 8;
    localparam int M = 147;
    logic clk = 1'b0;
    logic rst = 1'b1;
    polyphase_sched_if #(.L_LOG(L_LOG)) bus ();
    polyphase_sched #(.L(L), .L_LOG(L_LOG), .M(M)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    int n_chk = 0;
    int n_pass = 0;
    task automatic chk(input string tag, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    endtask
    // stimulus controls, written by the scenario only right after a falling edge
    logic rnd = 1'b0;
    logic spur = 1'b0;
    logic hold_ao = 1'b0;
    logic run_ctl = 1'b0;
    logic ack_in_tie = 1'b1;
    int done_dly = 0;
    // environment: upstream, downstream and a datapath answering start after done_dly+1 cycles
    int cd = -1;
    logic st;
    initial begin
        bus.run = 1'b0;
        bus.ack_in = 1'b0;
        bus.ack_out = 1'b0;
        bus.done = 1'b0;
        forever begin
            @(negedge clk);
            st = bus.start;
            @(posedge clk);
            #1;
            if (st) cd = rnd ? int'($urandom_range(3)) : done_dly;
            else if (cd >= 0) cd--;
            bus.done = cd == 0 || ((rnd || spur) && $urandom_range(7) == 0);
            bus.ack_in = rnd ? $urandom_range(1) == 1 : ack_in_tie;
            bus.ack_out = hold_ao ? 1'b0 : rnd ? $urandom_range(1) == 1 : 1'b1;
            bus.run = rnd ? $urandom_range(7) != 0 : run_ctl;
        end
    end
    // reference model: output k uses branch (k*M) mod L and needs floor(k*M/L)+1 samples accepted before it
    int n_shift = 0;
    int n_start = 0;
    int n_out = 0;
    logic p_fx = 1'b0;
    logic p_start = 1'b0;
    logic p_run = 1'b0;
    logic [L_LOG-1:0] hold_ph = '0;
    int ph_log[$];
    int sh_log[$];
    initial forever begin
        @(negedge clk);
        if (rst) begin
            n_shift = 0;
            n_start = 0;
            n_out = 0;
            p_fx = 1'b0;
            p_start = 1'b0;
            p_run = 1'b0;
            ph_log.delete();
            sh_log.delete();
        end else begin
            chk("req_excl", bus.req_in && bus.req_out, 0);
            chk("pulse_excl", bus.shift_en && bus.start, 0);
            chk("shift_after_ack", bus.shift_en, p_fx);
            if (bus.shift_en) n_shift++;
            if (bus.start) begin
                chk("start_needs_run", p_run, 1);
                chk("start_width", p_start, 0);
                chk("phase", bus.phase, (n_start * M) % L);
                chk("fetches_before_out", n_shift, (n_start * M) / L + 1);
                ph_log.push_back(int'(bus.phase));
                sh_log.push_back(n_shift);
                hold_ph = bus.phase;
                n_start++;
            end
            if (bus.req_out) chk("phase_hold", bus.phase, hold_ph);
            if (bus.req_out && bus.ack_out) begin
                chk("out_cnt", bus.out_cnt, n_out & 16'hffff);
                n_out++;
            end
            p_fx = bus.req_in && bus.ack_in;
            p_start = bus.start;
            p_run = bus.run;
        end
    end
    task automatic wait_outs(input int target, input int budget);
        int i = 0;
        while (n_out < target && i < budget) begin
            @(posedge clk);
            i++;
        end
        chk("out_timeout", n_out >= target, 1);
    endtask
    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask
    int c;
    int i;
    logic [L_LOG-1:0] p0;
    initial begin
        if (L > 2**L_LOG || M >= 2**L_LOG) begin
            $display("FAIL params: L=%0d M=%0d L_LOG=%0d", L, M, L_LOG);
            $fatal(1);
        end
        run_ctl = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_in", bus.req_in, 0);
        chk("rst_req_out", bus.req_out, 0);
        chk("rst_shift_en", bus.shift_en, 0);
        chk("rst_start", bus.start, 0);
        chk("rst_phase", bus.phase, 0);
        chk("rst_out_cnt", bus.out_cnt, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        // first outputs and a full L-output period with everything tied ready
        wait_outs(3, 100);
        chk("ph0", ph_log.size() > 2 ? ph_log[0] : -1, 0);
        chk("ph1", ph_log.size() > 2 ? ph_log[1] : -1, 147);
        chk("ph2", ph_log.size() > 2 ? ph_log[2] : -1, 134);
        chk("sh0", sh_log.size() > 2 ? sh_log[0] : -1, 1);
        chk("sh1", sh_log.size() > 2 ? sh_log[1] : -1, 1);
        chk("sh2", sh_log.size() > 2 ? sh_log[2] : -1, 2);
        wait_outs(160, 3000);
        chk("shifts_per_period", n_shift, 147);
        @(negedge clk);
        chk("out_cnt_160", bus.out_cnt, 160);
        i = 0;
        while (n_start < 161 && i < 100) begin
            @(negedge clk);
            i++;
        end
        chk("phase_161", ph_log.size() > 160 ? ph_log[160] : -1, 0);
        // downstream stall in OUT
        @(negedge clk);
        hold_ao = 1'b1;
        i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (!bus.req_out && i < 100);
        p0 = bus.phase;
        c = n_out;
        for (int k = 0; k < 10; k++) begin
            chk("stall_req_out", bus.req_out, 1);
            chk("stall_start", bus.start, 0);
            chk("stall_phase", bus.phase, p0);
            chk("stall_out_cnt", bus.out_cnt, c & 16'hffff);
            @(negedge clk);
        end
        hold_ao = 1'b0;
        wait_outs(c + 3, 100);
        // run dropped during WAIT; spurious done/ack_in while idle in ADVANCE
        @(negedge clk);
        done_dly = 3;
        i = 0;
        while (!bus.start && i < 100) begin
            @(negedge clk);
            i++;
        end
        run_ctl = 1'b0;
        c = n_out;
        wait_outs(c + 1, 50);
        @(negedge clk);
        spur = 1'b1;
        repeat (10) @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            chk("idle_req_in", bus.req_in, 0);
            chk("idle_req_out", bus.req_out, 0);
            chk("idle_start", bus.start, 0);
            chk("idle_shift_en", bus.shift_en, 0);
            chk("idle_out_cnt", bus.out_cnt, n_out & 16'hffff);
            @(negedge clk);
        end
        chk("idle_fetches_done", n_shift, (n_out * M) / L + 1);
        spur = 1'b0;
        done_dly = 0;
        run_ctl = 1'b1;
        wait_outs(n_out + 5, 200);
        // reset while a fetch is pending
        @(negedge clk);
        ack_in_tie = 1'b0;
        i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (!bus.req_in && i < 200);
        chk("fetch_pending", bus.req_in, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_req_in", bus.req_in, 0);
        chk("mid_rst_req_out", bus.req_out, 0);
        chk("mid_rst_out_cnt", bus.out_cnt, 0);
        chk("mid_rst_shift_en", bus.shift_en, 0);
        chk("mid_rst_start", bus.start, 0);
        ack_in_tie = 1'b1;
        @(negedge clk);
        chk("mid_rst_shift_en2", bus.shift_en, 0);
        chk("mid_rst_start2", bus.start, 0);
        wait_outs(1, 50);
        chk("mid_rst_phase0", ph_log.size() > 0 ? ph_log[0] : -1, 0);
        // randomized handshakes, datapath delay and run, with one reset in the middle
        @(negedge clk);
        rnd = 1'b1;
        c = n_out;
        repeat (1500) @(posedge clk);
        chk("rand_progress", n_out > c, 1);
        do_reset();
        repeat (1500) @(posedge clk);
        chk("rand_progress2", n_out > 20, 1);
        @(negedge clk);
        rnd = 1'b0;
        repeat (20) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
